// File: rtl/spi_flash_pkg.sv
// Shared types and constants for the SPI flash arbiter: FSM states, bus widths, requester IDs.
package spi_flash_pkg;

    localparam int unsigned ADDR_W = 24;
    localparam int unsigned DATA_W = 32;

    typedef enum logic [1:0] {
        ST_WAIT_INIT = 2'd0,
        ST_IDLE      = 2'd1,
        ST_ISSUE     = 2'd2,
        ST_RESP      = 2'd3
    } state_e;

    typedef enum logic {
        REQ_I = 1'b0,
        REQ_D = 1'b1
    } req_id_e;

endpackage

// File: rtl/spi_flash_arbiter_if.sv
// Requester and flash-reader signal bundle; slave = arbiter side, master = requesters/reader side.
interface spi_flash_arbiter_if;
    import spi_flash_pkg::*;

    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_ack;
    logic [DATA_W-1:0] i_data;
    logic              d_req;
    logic [ADDR_W-1:0] d_addr;
    logic              d_ack;
    logic [DATA_W-1:0] d_data;
    logic              flash_start;
    logic [ADDR_W-1:0] flash_addr;
    logic [DATA_W-1:0] flash_data;
    logic              flash_init_done;
    logic              flash_recv_done;

    modport slave (
        input  i_req, i_addr, d_req, d_addr, flash_data, flash_init_done, flash_recv_done,
        output i_ack, i_data, d_ack, d_data, flash_start, flash_addr
    );

    modport master (
        output i_req, i_addr, d_req, d_addr, flash_data, flash_init_done, flash_recv_done,
        input  i_ack, i_data, d_ack, d_data, flash_start, flash_addr
    );

endinterface

// File: rtl/spi_flash_rr_arb.sv
// Two-way round-robin grant between instruction and data requesters with a last-grant register.
module spi_flash_rr_arb
    import spi_flash_pkg::*;
(
    input  logic    clk,
    input  logic    reset_n,
    input  logic    i_req,
    input  logic    d_req,
    input  logic    upd,
    input  req_id_e upd_id,
    output logic    grant_valid_c,
    output req_id_e grant_id_c
);

    req_id_e last_q;

    // Starts as d so that i wins the first tie.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_q <= REQ_D;
        end else if (upd) begin
            last_q <= upd_id;
        end
    end

    always_comb begin
        grant_valid_c = i_req | d_req;
        grant_id_c    = REQ_I;
        if (i_req && d_req) begin
            grant_id_c = (last_q == REQ_I) ? REQ_D : REQ_I;
        end else if (d_req) begin
            grant_id_c = REQ_D;
        end
    end

endmodule

// File: rtl/spi_flash_arbiter.sv
// Arbitrates i/d word reads onto a single SPI flash reader.
// Optional one-entry last-word cache enabled by SPI_FLASH_ARB_CACHE_EN.
module spi_flash_arbiter
    import spi_flash_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
    spi_flash_arbiter_if.slave bus,
    output logic               busy
);

    state_e            state_q, next_state;
    req_id_e           gnt_q, grant_id_c, resp_id_c;
    logic              grant_valid_c, upd_c;
    logic              recv_prev_q, recv_rise_c;
    logic              take_c, hit_c, resp_load_c;
    logic [ADDR_W-1:0] addr_q, sel_addr_c;
    logic [DATA_W-1:0] i_data_q, d_data_q, resp_word_c;
    logic              flash_start_q, i_ack_q, d_ack_q, busy_q;

    assign upd_c = (state_q == ST_RESP);

    spi_flash_rr_arb u_arb (
        .clk           (clk),
        .reset_n       (reset_n),
        .i_req         (bus.i_req),
        .d_req         (bus.d_req),
        .upd           (upd_c),
        .upd_id        (gnt_q),
        .grant_valid_c (grant_valid_c),
        .grant_id_c    (grant_id_c)
    );

    // Only the first high cycle of the two-cycle recv_done pulse counts.
    assign recv_rise_c = bus.flash_recv_done & ~recv_prev_q;
    assign sel_addr_c  = (grant_id_c == REQ_I) ? bus.i_addr : bus.d_addr;
    assign resp_id_c   = (state_q == ST_IDLE) ? grant_id_c : gnt_q;

`ifdef SPI_FLASH_ARB_CACHE_EN
    logic              cache_valid_q;
    logic [ADDR_W-1:0] cache_tag_q;
    logic [DATA_W-1:0] cache_data_q;

    assign hit_c       = cache_valid_q && (cache_tag_q == sel_addr_c);
    assign resp_word_c = (state_q == ST_IDLE) ? cache_data_q : bus.flash_data;

    // Refilled on every miss completion.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cache_valid_q <= 1'b0;
            cache_tag_q   <= '0;
            cache_data_q  <= '0;
        end else if (resp_load_c && (state_q == ST_ISSUE)) begin
            cache_valid_q <= 1'b1;
            cache_tag_q   <= addr_q;
            cache_data_q  <= bus.flash_data;
        end
    end
`else
    assign hit_c       = 1'b0;
    assign resp_word_c = bus.flash_data;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_WAIT_INIT;
        end else begin
            state_q <= next_state;
        end
    end

    always_comb begin
        next_state  = state_q;
        take_c      = 1'b0;
        resp_load_c = 1'b0;
        case (state_q)
            ST_WAIT_INIT: begin
                if (bus.flash_init_done) begin
                    next_state = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (grant_valid_c) begin
                    take_c = 1'b1;
                    if (hit_c) begin
                        next_state  = ST_RESP;
                        resp_load_c = 1'b1;
                    end else begin
                        next_state = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                if (recv_rise_c) begin
                    next_state  = ST_RESP;
                    resp_load_c = 1'b1;
                end
            end
            ST_RESP: next_state = ST_IDLE;
            default: next_state = ST_WAIT_INIT;
        endcase
    end

    // Outputs are registered against next_state so they line up with the state they describe.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            recv_prev_q   <= 1'b0;
            gnt_q         <= REQ_I;
            addr_q        <= '0;
            flash_start_q <= 1'b0;
            i_ack_q       <= 1'b0;
            d_ack_q       <= 1'b0;
            i_data_q      <= '0;
            d_data_q      <= '0;
            busy_q        <= 1'b0;
        end else begin
            recv_prev_q   <= bus.flash_recv_done;
            flash_start_q <= (next_state == ST_ISSUE);
            busy_q        <= (next_state != ST_IDLE);
            i_ack_q       <= resp_load_c && (resp_id_c == REQ_I);
            d_ack_q       <= resp_load_c && (resp_id_c == REQ_D);
            if (take_c) begin
                gnt_q  <= grant_id_c;
                addr_q <= sel_addr_c;
            end
            if (resp_load_c && (resp_id_c == REQ_I)) begin
                i_data_q <= resp_word_c;
            end
            if (resp_load_c && (resp_id_c == REQ_D)) begin
                d_data_q <= resp_word_c;
            end
        end
    end

    assign bus.flash_start = flash_start_q;
    assign bus.flash_addr  = addr_q;
    assign bus.i_ack       = i_ack_q;
    assign bus.i_data      = i_data_q;
    assign bus.d_ack       = d_ack_q;
    assign bus.d_data      = d_data_q;
    assign busy            = busy_q;

endmodule

// File: tb/tb_spi_flash_arbiter.sv
// Directed scoreboard bench for spi_flash_arbiter with a behavioural flash-reader model.
module tb_spi_flash_arbiter;
    import spi_flash_pkg::*;

    typedef struct {
        logic        id;
        logic [23:0] addr;
        logic [31:0] data;
    } exp_t;

    logic clk;
    logic reset_n;
    logic busy;

    spi_flash_arbiter_if bus ();

    spi_flash_arbiter dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus),
        .busy    (busy)
    );

    exp_t        exp_q[$];
    logic [23:0] addr_log[$];
    int          checks    = 0;
    int          failures  = 0;
    int          model_lat = 5;
    int          fair_left = 0;
    int          starts    = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] word_of(input logic [23:0] a);
        if (a == 24'h000010) return 32'hDEADBEEF;
        return {8'h5A, a} ^ 32'h0F0F_0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic push_exp(input logic id, input logic [23:0] a);
        exp_t e;
        e.id   = id;
        e.addr = a;
        e.data = word_of(a);
        exp_q.push_back(e);
    endtask

    // Call right after a negedge; cyc counts the request cycle through the ack cycle inclusive.
    task automatic do_read(input logic id, input logic [23:0] a, output int cyc);
        push_exp(id, a);
        if (id == 1'b0) begin
            bus.i_addr = a;
            bus.i_req  = 1'b1;
        end else begin
            bus.d_addr = a;
            bus.d_req  = 1'b1;
        end
        cyc = 0;
        for (int n = 1; n <= 2000; n++) begin
            @(negedge clk);
            if ((id == 1'b0 && bus.i_ack) || (id == 1'b1 && bus.d_ack)) begin
                cyc = n + 1;
                break;
            end
        end
        if (cyc == 0) chk("read_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_empty(input string tag, input int budget);
        for (int n = 0; n < budget; n++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        chk(tag, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic ack_seen(input logic id, input logic [31:0] data);
        exp_t e;
        chk("ack_has_expect", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("ack_port", 32'(id), 32'(e.id));
            chk("ack_data", data, e.data);
        end
        if (fair_left > 0) begin
            fair_left--;
            if (fair_left == 0) begin
                bus.i_req = 1'b0;
                bus.d_req = 1'b0;
            end
        end else if (id == 1'b0) begin
            bus.i_req = 1'b0;
        end else begin
            bus.d_req = 1'b0;
        end
    endtask

    // Flash reader: after flash_start, wait model_lat cycles, then hold recv_done for two cycles.
    initial begin
        logic [23:0] a;
        logic        ok;
        bus.flash_recv_done = 1'b0;
        bus.flash_data      = '0;
        forever begin
            @(posedge clk);
            #1;
            if (reset_n && bus.flash_start) begin
                a  = bus.flash_addr;
                ok = 1'b1;
                for (int k = 0; k < model_lat; k++) begin
                    @(posedge clk);
                    #1;
                    if (!reset_n || !bus.flash_start) begin
                        ok = 1'b0;
                        break;
                    end
                end
                if (ok) begin
                    bus.flash_data      = word_of(a);
                    bus.flash_recv_done = 1'b1;
                    @(posedge clk);
                    #1;
                    @(posedge clk);
                    #1;
                    bus.flash_recv_done = 1'b0;
                end
            end
        end
    end

    // Output monitor: scoreboard pops, start logging, flash_start timing around recv_done.
    initial begin
        logic prev_fs;
        logic prev_rd;
        logic rise_pend;
        prev_fs   = 1'b0;
        prev_rd   = 1'b0;
        rise_pend = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                prev_fs   = 1'b0;
                prev_rd   = 1'b0;
                rise_pend = 1'b0;
            end else begin
                if (rise_pend) begin
                    chk("fs_low_after_rise", 32'(bus.flash_start), 32'd0);
                    rise_pend = 1'b0;
                end
                if (bus.flash_recv_done && !prev_rd) begin
                    chk("fs_high_at_rise", 32'(bus.flash_start), 32'd1);
                    rise_pend = 1'b1;
                end
                if (bus.flash_start && !prev_fs) begin
                    addr_log.push_back(bus.flash_addr);
                    starts++;
                end
                if (bus.i_ack || bus.d_ack) chk("single_ack", 32'(bus.i_ack & bus.d_ack), 32'd0);
                if (bus.i_ack) ack_seen(1'b0, bus.i_data);
                if (bus.d_ack) ack_seen(1'b1, bus.d_data);
                prev_fs = bus.flash_start;
                prev_rd = bus.flash_recv_done;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, "_fs"},     32'(bus.flash_start), 32'd0);
        chk({tag, "_iack"},   32'(bus.i_ack),       32'd0);
        chk({tag, "_dack"},   32'(bus.d_ack),       32'd0);
        chk({tag, "_busy"},   32'(busy),            32'd0);
        chk({tag, "_faddr"},  32'(bus.flash_addr),  32'd0);
        chk({tag, "_idata"},  bus.i_data,           32'd0);
        chk({tag, "_ddata"},  bus.d_data,           32'd0);
    endtask

    initial begin
        int cyc;
        int c1;
        int c2;
        int s0;

        reset_n             = 1'b0;
        bus.i_req           = 1'b0;
        bus.i_addr          = '0;
        bus.d_req           = 1'b0;
        bus.d_addr          = '0;
        bus.flash_init_done = 1'b0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        reset_n = 1'b1;

        // Init gate: request pending while the reader is not initialised.
        @(negedge clk);
        push_exp(1'b0, 24'h000020);
        bus.i_addr = 24'h000020;
        bus.i_req  = 1'b1;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            chk("init_gate_fs", 32'(bus.flash_start), 32'd0);
        end
        chk("wait_init_busy", 32'(busy), 32'd1);
        bus.flash_init_done = 1'b1;
        repeat (2) @(negedge clk);
        chk("fs_after_init", 32'(bus.flash_start), 32'd1);
        wait_empty("init_read_done", 200);

        // Single read with a 60-cycle reader.
        model_lat = 60;
        @(negedge clk);
        do_read(1'b0, 24'h000010, cyc);
        chk("single_latency", 32'(cyc), 32'd63);

        // d-port read; i_data must hold.
        model_lat = 5;
        @(negedge clk);
        do_read(1'b1, 24'h000300, cyc);
        chk("d_latency", 32'(cyc), 32'd8);
        chk("i_data_hold", bus.i_data, 32'hDEADBEEF);

        // Contention: simultaneous requests, i first.
        @(negedge clk);
        addr_log.delete();
        push_exp(1'b0, 24'h000100);
        push_exp(1'b1, 24'h000200);
        bus.i_addr = 24'h000100;
        bus.d_addr = 24'h000200;
        bus.i_req  = 1'b1;
        bus.d_req  = 1'b1;
        wait_empty("contention_done", 300);
        chk("contention_starts", 32'(addr_log.size()), 32'd2);
        if (addr_log.size() >= 2) begin
            chk("contention_addr0", 32'(addr_log[0]), 32'h000100);
            chk("contention_addr1", 32'(addr_log[1]), 32'h000200);
        end

        // Fairness: both held for six transactions.
        @(negedge clk);
        addr_log.delete();
        fair_left  = 6;
        bus.i_addr = 24'h000500;
        bus.d_addr = 24'h000600;
        for (int k = 0; k < 6; k++) begin
            push_exp(1'(k % 2), (k % 2 == 0) ? 24'h000500 : 24'h000600);
        end
        bus.i_req = 1'b1;
        bus.d_req = 1'b1;
        wait_empty("fairness_done", 600);
        chk("fairness_starts", 32'(addr_log.size()), 32'd6);

        // Request dropped early and address changed while pending: latched address still served.
        @(negedge clk);
        push_exp(1'b1, 24'h000700);
        bus.d_addr = 24'h000700;
        bus.d_req  = 1'b1;
        @(negedge clk);
        bus.d_addr = 24'h000777;
        repeat (2) @(negedge clk);
        bus.d_req = 1'b0;
        wait_empty("dropped_req_ack", 100);

        // Reset during ISSUE.
        model_lat = 40;
        @(negedge clk);
        bus.i_addr = 24'h000800;
        bus.i_req  = 1'b1;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (bus.flash_start) break;
        end
        chk("issue_reached", 32'(bus.flash_start), 32'd1);
        repeat (5) @(negedge clk);
        reset_n             = 1'b0;
        bus.flash_init_done = 1'b0;
        bus.i_req           = 1'b0;
        @(negedge clk);
        chk_all_zero("mid_reset");
        @(negedge clk);
        reset_n = 1'b1;
        model_lat = 10;
        push_exp(1'b0, 24'h000810);
        bus.i_addr = 24'h000810;
        bus.i_req  = 1'b1;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            chk("post_reset_gate_fs", 32'(bus.flash_start), 32'd0);
        end
        chk("post_reset_busy", 32'(busy), 32'd1);
        bus.flash_init_done = 1'b1;
        wait_empty("post_reset_read", 200);

        // Back-to-back reads of the same address.
        @(negedge clk);
        s0 = starts;
        do_read(1'b0, 24'h000040, c1);
        chk("repeat_first_latency", 32'(c1), 32'd13);
        @(negedge clk);
        do_read(1'b0, 24'h000040, c2);
`ifdef SPI_FLASH_ARB_CACHE_EN
        chk("repeat_hit_latency", 32'(c2), 32'd2);
        chk("repeat_starts", 32'(starts - s0), 32'd1);
`else
        chk("repeat_miss_latency", 32'(c2), 32'd13);
        chk("repeat_starts", 32'(starts - s0), 32'd2);
`endif

        repeat (5) @(negedge clk);
        chk("final_drain", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
